// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer and IF/ID register (optional perf counters: FETCH_CTRL_PERF_EN)
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_pc;
    logic [31:0] redirect_aligned;
    logic        do_advance;
    logic        do_stall;
    logic        do_flush;

    assign redirect_aligned = {i_redirect_pc[31:2], 2'b00};
    assign do_flush         = i_redirect;
    assign do_stall         = !i_redirect && i_stall;
    assign do_advance       = !i_redirect && !i_stall;

    // State register; reset parks the sequencer in BUBBLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BUBBLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: redirect beats stall, which beats advance, from any state
    always_comb begin
        state_nxt = state;
        case (state)
            RUN, HOLD, BUBBLE: begin
                if (do_flush) begin
                    state_nxt = BUBBLE;
                end else if (do_stall) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BUBBLE;
        endcase
    end

    // Pre-fetch address: stall re-reads req_pc so its word is still on the bus next cycle
    always_comb begin
        o_imem_addr = req_pc + 32'd4;
        if (!rst) begin
            o_imem_addr = RESET_PC;
        end else if (do_flush) begin
            o_imem_addr = redirect_aligned;
        end else if (do_stall) begin
            o_imem_addr = req_pc;
        end
    end

    // IF/ID register and in-flight address tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_pc  <= RESET_PC;
            o_pc    <= 32'h0;
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (do_flush) begin
            req_pc  <= redirect_aligned;
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (do_advance) begin
            o_pc    <= req_pc;
            o_instr <= i_imem_data;
            o_valid <= 1'b1;
            req_pc  <= req_pc + 32'd4;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating event counters, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (do_advance && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
            if (do_stall   && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            if (do_flush   && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = fetch_cnt;
    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_fetch_cnt = 32'h0;
    assign o_stall_cnt = 32'h0;
    assign o_flush_cnt = 32'h0;
`endif

endmodule
